// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-side datapath blocks:
// default product width, the dot-accumulator state encoding and
// the run-length clamp helper.
package mult_pkg;

   // Product width of the 4x4 multiplier array (2 x operand width).
   localparam int PROD_W_DEF = 8;

   // Dot-accumulator run states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Limit a requested run length to the largest supported length.
   function automatic int clamp_len(input int len_v, input int max_v);
      int res_v;
      if (len_v > max_v) begin
         res_v = max_v;
      end else begin
         res_v = len_v;
      end
      return res_v;
   endfunction

endpackage : mult_pkg

// File: rtl/dot_acc_adder.sv
// Unsigned ACC_W-bit adder with carry-out for the dot accumulator.
// With DOT_ACCUM_SAT_EN defined, any add that carries out clamps the
// sum to all-ones; otherwise the sum wraps modulo 2^ACC_W. Once the
// accumulator sits at all-ones, every further add either carries or
// adds zero, so a saturated sum stays saturated for the rest of the run.
module dot_acc_adder #(
   parameter int ACC_W = 16
)(
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W-1:0] raw_sum_s;
   logic             raw_carry_s;

   // Full-width add, keeping the carry out of the top bit.
   always_comb begin
      {raw_carry_s, raw_sum_s} = {1'b0, a} + {1'b0, b};
   end

   // Select wrapped or saturated result.
   always_comb begin
      carry = raw_carry_s;
`ifdef DOT_ACCUM_SAT_EN
      if (raw_carry_s) begin
         sum = {ACC_W{1'b1}};
      end else begin
         sum = raw_sum_s;
      end
`else
      sum = raw_sum_s;
`endif
   end

endmodule : dot_acc_adder

// File: rtl/mult_dot_accum.sv
// Dot-product / MAC reduction stage behind the combinational 4x4
// multiplier. A run of len products is accepted over a valid/ready
// handshake and summed; the registered result is then offered on a
// valid/ready output together with a sticky overflow flag.
// Optional build macro: DOT_ACCUM_SAT_EN (saturating accumulation).
module mult_dot_accum
   import mult_pkg::*;
#(
   parameter  int PROD_W  = PROD_W_DEF,
   parameter  int ACC_W   = 16,
   parameter  int MAX_LEN = 16,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_ovf,
   output logic              busy
);

   state_t            state_r;
   logic [ACC_W-1:0]  acc_r;
   logic [LEN_W-1:0]  cnt_r;
   logic              ovf_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              busy_r;
   logic [ACC_W-1:0]  out_acc_r;
   logic              out_ovf_r;

   logic [ACC_W-1:0]  prod_ext_s;
   logic [ACC_W-1:0]  sum_s;
   logic              carry_s;
   logic              accept_s;
   logic              last_s;
   logic [LEN_W-1:0]  len_clamped_s;

   // Zero-extend the product and clamp the requested length.
   always_comb begin
      prod_ext_s    = ACC_W'(in_prod);
      len_clamped_s = LEN_W'(clamp_len(int'(len), MAX_LEN));
   end

   // Handshake decode: in_ready is only ever high in ACCUM.
   always_comb begin
      if (in_ready_r) begin
         accept_s = in_valid;
         last_s   = (cnt_r == LEN_W'(1));
      end else begin
         accept_s = 1'b0;
         last_s   = 1'b0;
      end
   end

   dot_acc_adder #(
      .ACC_W (ACC_W)
   ) u_adder (
      .a     (acc_r),
      .b     (prod_ext_s),
      .sum   (sum_s),
      .carry (carry_s)
   );

   // Run-control FSM with accumulator, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= {ACC_W{1'b0}};
         cnt_r       <= {LEN_W{1'b0}};
         ovf_r       <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_acc_r   <= {ACC_W{1'b0}};
         out_ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  acc_r  <= {ACC_W{1'b0}};
                  ovf_r  <= 1'b0;
                  busy_r <= 1'b1;
                  if (len != {LEN_W{1'b0}}) begin
                     cnt_r      <= len_clamped_s;
                     in_ready_r <= 1'b1;
                     state_r    <= ACCUM;
                  end else begin
                     // Empty run: publish a zero result straight away.
                     out_acc_r   <= {ACC_W{1'b0}};
                     out_ovf_r   <= 1'b0;
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCUM: begin
               if (accept_s) begin
                  acc_r <= sum_s;
                  ovf_r <= ovf_r | carry_s;
                  cnt_r <= cnt_r - LEN_W'(1);
                  if (last_s) begin
                     out_acc_r   <= sum_s;
                     out_ovf_r   <= ovf_r | carry_s;
                     out_valid_r <= 1'b1;
                     in_ready_r  <= 1'b0;
                     state_r     <= DONE;
                  end else begin
                     state_r <= ACCUM;
                  end
               end else begin
                  state_r <= ACCUM;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Drive ports from registers only.
   always_comb begin
      in_ready  = in_ready_r;
      out_valid = out_valid_r;
      busy      = busy_r;
      out_acc   = out_acc_r;
      out_ovf   = out_ovf_r;
   end

endmodule : mult_dot_accum

// File: tb/tb_mult_dot_accum.sv
// Directed self-checking bench for mult_dot_accum (ACC_W=10, MAX_LEN=16).
module tb_mult_dot_accum;

   localparam int PROD_W  = 8;
   localparam int ACC_W   = 10;
   localparam int MAX_LEN = 16;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

`ifdef DOT_ACCUM_SAT_EN
   localparam logic [31:0] OVF_EXP = 32'd1023;
`else
   localparam logic [31:0] OVF_EXP = 32'd101;
`endif

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic              out_ovf;
   logic              busy;

   int n_checks;
   int n_errors;
   int n_accepted;

   mult_dot_accum #(
      .PROD_W  (PROD_W),
      .ACC_W   (ACC_W),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_run(input int l);
      start = 1'b1;
      len   = LEN_W'(l);
      step();
      start = 1'b0;
   endtask

   // One product with 'gap' idle cycles afterwards.
   task automatic send(input int p, input int gap);
      in_valid = 1'b1;
      in_prod  = PROD_W'(p);
      step();
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
      in_prod = '0; out_ready = 1'b0;
      #23;
      check_val("rst_in_ready", 32'(in_ready), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_out_acc", 32'(out_acc), 32'd0);
      check_val("rst_out_ovf", 32'(out_ovf), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic run: 4 x 225 = 900.
      begin_run(4);
      check_val("basic_in_ready", 32'(in_ready), 32'd1);
      check_val("basic_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         send(225, 0);
         check_val("basic_no_early_valid", 32'(out_valid), 32'd0);
      end
      send(225, 0);
      check_val("basic_out_valid", 32'(out_valid), 32'd1);
      check_val("basic_out_acc", 32'(out_acc), 32'd900);
      check_val("basic_out_ovf", 32'(out_ovf), 32'd0);
      check_val("basic_done_in_ready", 32'(in_ready), 32'd0);
      release_result();
      check_val("basic_idle_valid", 32'(out_valid), 32'd0);
      check_val("basic_idle_busy", 32'(busy), 32'd0);
      check_val("basic_hold_acc", 32'(out_acc), 32'd900);

      // Bubbles and backpressure: 5+7+9 = 21.
      begin_run(3);
      send(5, 2);
      check_val("bub_in_ready", 32'(in_ready), 32'd1);
      send(7, 2);
      check_val("bub_no_valid", 32'(out_valid), 32'd0);
      send(9, 0);
      for (int i = 0; i < 3; i++) begin
         check_val("bp_out_valid", 32'(out_valid), 32'd1);
         check_val("bp_out_acc", 32'(out_acc), 32'd21);
         step();
      end
      release_result();
      check_val("bp_idle_valid", 32'(out_valid), 32'd0);
      check_val("bp_idle_busy", 32'(busy), 32'd0);

      // Zero length.
      begin_run(0);
      check_val("zero_in_ready", 32'(in_ready), 32'd0);
      check_val("zero_out_valid", 32'(out_valid), 32'd1);
      check_val("zero_out_acc", 32'(out_acc), 32'd0);
      release_result();
      check_val("zero_idle_valid", 32'(out_valid), 32'd0);

      // Overflow: 5 x 225 = 1125 in a 10-bit accumulator.
      begin_run(5);
      for (int i = 0; i < 5; i++) send(225, 0);
      check_val("ovf_out_valid", 32'(out_valid), 32'd1);
      check_val("ovf_out_acc", 32'(out_acc), OVF_EXP);
      check_val("ovf_out_ovf", 32'(out_ovf), 32'd1);
      release_result();

      // Clamp len=20 to 16, with a start pulse mid-run.
      begin_run(20);
      n_accepted = 0;
      in_prod = PROD_W'(1);
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         if (in_ready) n_accepted++;
         if (i == 5) begin
            start = 1'b1;
            len   = LEN_W'(3);
         end else begin
            start = 1'b0;
         end
         step();
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check_val("clamp_accepted", 32'(n_accepted), 32'd16);
      check_val("clamp_out_valid", 32'(out_valid), 32'd1);
      check_val("clamp_out_acc", 32'(out_acc), 32'd16);
      check_val("clamp_ovf_cleared", 32'(out_ovf), 32'd0);
      check_val("clamp_in_ready", 32'(in_ready), 32'd0);
      release_result();

      // Reset mid-run.
      begin_run(4);
      send(10, 0);
      send(20, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("midrst_in_ready", 32'(in_ready), 32'd0);
      check_val("midrst_busy", 32'(busy), 32'd0);
      check_val("midrst_out_valid", 32'(out_valid), 32'd0);
      check_val("midrst_out_acc", 32'(out_acc), 32'd0);
      #3;
      rst_n = 1'b1;
      step();
      begin_run(1);
      send(3, 0);
      check_val("post_rst_valid", 32'(out_valid), 32'd1);
      check_val("post_rst_acc", 32'(out_acc), 32'd3);
      release_result();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_mult_dot_accum

// File: doc/mult_dot_accum.md
Name: mult_dot_accum

Overview:
- Downstream consumer of the 4x4 combinational multiplier's 8-bit product bus.
- Accumulates a programmed number of products (dot-product / MAC reduction) under a valid/ready handshake, then presents one registered sum.
- Sits between the multiplier array output and the result sink; the upstream multiplier stays purely combinational.

Parameters:
- PROD_W, 8: width of the incoming product (2 x operand width).
- ACC_W, 16: accumulator and result width; must be >= PROD_W.
- MAX_LEN, 16: maximum number of products per run.
- LEN_W, $clog2(MAX_LEN+1): width of the length field (derived localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- len  input  LEN_W  number of products in the run; sampled with start.
- in_valid  input  1  product valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- out_acc  output  ACC_W  accumulated sum.
- out_ovf  output  1  sticky flag: the run overflowed ACC_W.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: state=IDLE, acc=0, cnt=0, out_ovf=0, in_ready=0, out_valid=0, busy=0, out_acc=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with len!=0: acc<=0, ovf<=0, cnt<=min(len,MAX_LEN), go to ACCUM.
  - start=1 with len==0: acc<=0, ovf<=0, go to DONE. out_valid rises the next cycle with out_acc=0.
- ACCUM:
  - in_ready=1 (combinational from state only; no dependency on in_valid).
  - Each cycle in which in_valid and in_ready are both high: acc<=acc+zero_ext(in_prod), cnt<=cnt-1.
  - Accepting the product when cnt==1 moves the FSM to DONE.
  - Bubbles (in_valid=0) leave acc and cnt unchanged, with no timeout.
- DONE:
  - out_valid=1; out_acc and out_ovf hold stable until out_ready=1.
  - When out_valid and out_ready are both high: go to IDLE. out_acc and out_ovf keep their last values and out_valid drops.
- Latency: out_valid asserts the cycle after the final product is accepted. A 1-cycle output register applies; there is no combinational path from in_prod to out_acc.
- Arithmetic: unsigned, modulo 2^ACC_W. A carry out of bit ACC_W-1 on any accepted add sets ovf, which stays set until the next start.
- start in ACCUM or DONE is ignored and len is not resampled.
- Throughput: one product per cycle in ACCUM. Minimum run turnaround is len+2 cycles when out_ready is held high.
- Async reset mid-run aborts immediately and returns all outputs to their reset values. The partial sum is discarded.

Optional Feature:
- Macro DOT_ACCUM_SAT_EN.
- Defined: on overflow, acc saturates to all-ones ({ACC_W{1'b1}}) and stays there for the rest of the run. out_ovf is still set.
- Undefined: wrap-around modulo 2^ACC_W as specified above.

Decomposition:
- Shared package mult_pkg holds:
  - PROD_W default constant.
  - state typedef enum {IDLE, ACCUM, DONE}.
  - Helper function for clamping len to MAX_LEN.
- One sub-module, dot_acc_adder: ACC_W-bit unsigned add with carry-out, plus the saturation mux under DOT_ACCUM_SAT_EN.
- FSM, counter and output register remain in mult_dot_accum.

Test Plan:
- Basic run:
  - Stimulus: start, len=4, four back-to-back products 0xE1 (225).
  - Response: out_valid one cycle after the 4th accept, out_acc=0x0384 (900), out_ovf=0.
- Bubbles and backpressure:
  - Stimulus: len=3, products 5, 7, 9 with 2 idle cycles between each; out_ready low for 3 cycles in DONE.
  - Response: out_acc=21, held stable with out_valid=1 until out_ready rises, then IDLE.
- Zero length:
  - Stimulus: start with len=0.
  - Response: in_ready never asserts, out_valid the next cycle with out_acc=0.
- Overflow (ACC_W=10):
  - Stimulus: len=5, five products 225 (sum 1125).
  - Response without DOT_ACCUM_SAT_EN: out_acc=101, out_ovf=1.
  - Response with DOT_ACCUM_SAT_EN: out_acc=1023, out_ovf=1.
- Clamp and ignored start:
  - Stimulus: len=20 with MAX_LEN=16, seventeen products of 1, start pulsed mid-run.
  - Response: exactly 16 accepted, out_acc=16. in_ready=0 in DONE blocks the 17th. The mid-run start has no effect.
- Reset mid-run:
  - Stimulus: rst_n low after 2 of 4 products accepted.
  - Response: all outputs reset immediately. A new run with len=1, product 3 yields out_acc=3.
